key_conditioner: RTL

- Input-conditioning stage that sits directly upstream of the stopwatch core.
- Takes the board's raw active-low push-buttons (reset, start/pause, display hold) and synchronises them to clk.
- Debounces each key with a per-key state machine.
- Outputs clean debounced levels, single-cycle press/release pulses, and a single-cycle long-press pulse per key. The stopwatch core uses the press pulses instead of sampling raw keys itself.

---
 rtl/key_conditioner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: two-flop synchroniser, per-key debounce FSM, and
// registered level / press / release / long-press outputs for NUM_KEYS keys.
module key_conditioner #(
    parameter int NUM_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    // The hold counter must be able to represent LONG_PRESS_CYCLES itself.
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHECK,
        PRESSED,
        RELEASE_CHECK
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;

    // NOTE: synchroniser resets to 1 (released) so a held key is re-debounced after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t            state, state_next;
        logic [CNT_W-1:0]  cnt, cnt_next;
        logic [HOLD_W-1:0] hold, hold_next;
        logic              press_next, release_next, long_next, level_next;
        logic              level_q, press_q, release_q, long_q;

        // NOTE: every output of this block gets a default first, so no latch is inferred.
        always_comb begin
            state_next   = state;
            cnt_next     = cnt;
            press_next   = 1'b0;
            release_next = 1'b0;
            case (state)
                RELEASED: begin
                    if (!sync2[i]) begin
                        state_next = PRESS_CHECK;
                        cnt_next   = CNT_W'(1);
                    end
                end
                PRESS_CHECK: begin
                    if (sync2[i]) begin
                        state_next = RELEASED;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                        press_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync2[i]) begin
                        state_next = RELEASE_CHECK;
                        cnt_next   = CNT_W'(1);
                    end
                end
                RELEASE_CHECK: begin
                    if (!sync2[i]) begin
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next   = RELEASED;
                        cnt_next     = '0;
                        release_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end
            endcase
        end

        // Release and a fresh press both clear hold time; a release-check glitch does not.
        always_comb begin
            hold_next = hold;
            long_next = 1'b0;
            if (state_next == RELEASED) begin
                hold_next = '0;
            end else if (state == PRESS_CHECK && state_next == PRESSED) begin
                hold_next = '0;
            end else if ((state == PRESSED || state == RELEASE_CHECK) && hold != HOLD_MAX) begin
                hold_next = hold + HOLD_W'(1);
                long_next = (hold == HOLD_LAST);
            end
        end

        assign level_next = (state_next == PRESSED) || (state_next == RELEASE_CHECK);

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= RELEASED;
                cnt       <= '0;
                hold      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_next;
                cnt       <= cnt_next;
                hold      <= hold_next;
                level_q   <= level_next;
                press_q   <= press_next;
                release_q <= release_next;
                long_q    <= long_next;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule
